spi_reg_ctl: RTL and testbench

Frame controller that sits between the SPI byte-level slave and the block's register bank.
- Parses the received byte stream of each CS-low frame into a command byte followed by a data burst.
- Turns the burst into register write strobes or register read requests, with address auto-increment.
- Supplies the next MISO byte to the slave. Read data is prefetched a full byte-time ahead, so the slave's one-cycle load window after each received byte is always met.

---
 rtl/spi_reg_ctl.sv | 152 +++++++++++++++
 tb/tb_spi_reg_ctl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctl.sv
// spi_reg_ctl: frame controller between the SPI byte-level slave and the
// register bank. Each CS-low frame carries a command byte {rw, addr} and
// then a data burst. A write burst becomes write strobes, and a read burst
// becomes read requests; the address auto-increments in both cases. Read
// data is prefetched one byte-time ahead, so the next MISO byte is already
// loaded when the slave samples it in the cycle after each received byte.
module spi_reg_ctl #(
  parameter int unsigned ADDR_WIDTH  = 7,
  parameter logic [7:0]  STATUS_BYTE = 8'hA5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_byte_vld_i,
  input  logic [7:0]            spi_byte_data_i,
  output logic [7:0]            spi_byte_data_o,
  output logic [ADDR_WIDTH-1:0] reg_addr_o,
  output logic                  reg_wr_en_o,
  output logic [7:0]            reg_wr_data_o,
  output logic                  reg_rd_en_o,
  input  logic [7:0]            reg_rd_data_i,
  output logic                  frame_done_o
);

  localparam logic [2:0] S_CMD     = 3'd0;
  localparam logic [2:0] S_WR      = 3'd1;
  localparam logic [2:0] S_RD_REQ  = 3'd2;
  localparam logic [2:0] S_RD_CAP  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  logic [2:0]            state_q,    state_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]            pref_q,     pref_d;
  logic                  got_q,      got_d;
  logic [7:0]            miso_q,     miso_d;
  logic                  wr_en_q,    wr_en_d;
  logic [7:0]            wr_data_q,  wr_data_d;
  logic                  rd_en_q,    rd_en_d;

  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] addr_inc;

  assign cmd_addr = spi_byte_data_i[ADDR_WIDTH-1:0];
  assign addr_inc = addr_q + ADDR_WIDTH'(1);

  // Next-state logic: frame parsing, strobe generation and MISO selection.
  // The read strobe is registered on entry to S_RD_REQ, so it is high
  // exactly during the S_RD_REQ cycle and the data lands during S_RD_CAP.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    reg_addr_d = reg_addr_q;
    pref_d     = pref_q;
    got_d      = got_q;
    miso_d     = miso_q;
    wr_en_d    = 1'b0;
    wr_data_d  = wr_data_q;
    rd_en_d    = 1'b0;

    if (spi_cs_n_i) begin
      // A byte that completes together with CS rising is dropped here.
      state_d = S_CMD;
      miso_d  = '0;
      got_d   = 1'b0;
    end else begin
      if (spi_byte_vld_i) begin
        got_d = 1'b1;
      end
      case (state_q)
        S_CMD: begin
          if (spi_byte_vld_i) begin
            addr_d = cmd_addr;
            if (spi_byte_data_i[7]) begin
              miso_d     = STATUS_BYTE;
              rd_en_d    = 1'b1;
              reg_addr_d = cmd_addr;
              state_d    = S_RD_REQ;
            end else begin
              miso_d  = '0;
              state_d = S_WR;
            end
          end
        end
        S_WR: begin
          if (spi_byte_vld_i) begin
            wr_en_d    = 1'b1;
            wr_data_d  = spi_byte_data_i;
            reg_addr_d = addr_q;
            addr_d     = addr_inc;
            miso_d     = spi_byte_data_i;
          end
        end
        S_RD_REQ: begin
          state_d = S_RD_CAP;
        end
        S_RD_CAP: begin
          pref_d  = reg_rd_data_i;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          // Turnaround and data bytes are handled identically: the
          // prefetched byte goes out and the next address is requested.
          if (spi_byte_vld_i) begin
            miso_d     = pref_q;
            addr_d     = addr_inc;
            reg_addr_d = addr_inc;
            rd_en_d    = 1'b1;
            state_d    = S_RD_REQ;
          end
        end
        default: begin
          state_d = S_CMD;
        end
      endcase
    end
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_CMD;
      addr_q     <= '0;
      reg_addr_q <= '0;
      pref_q     <= '0;
      got_q      <= 1'b0;
      miso_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      rd_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      reg_addr_q <= reg_addr_d;
      pref_q     <= pref_d;
      got_q      <= got_d;
      miso_q     <= miso_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      rd_en_q    <= rd_en_d;
    end
  end

  assign spi_byte_data_o = miso_q;
  assign reg_addr_o      = reg_addr_q;
  assign reg_wr_en_o     = wr_en_q;
  assign reg_wr_data_o   = wr_data_q;
  assign reg_rd_en_o     = rd_en_q;
  // Pulses on the first CS-high cycle only: got_q clears at the end of it.
  assign frame_done_o    = spi_cs_n_i & got_q;

endmodule

// File: tb/tb_spi_reg_ctl.sv
// Directed bench for spi_reg_ctl: write/read bursts, address wrap, abort,
// vld coinciding with CS rising, and asynchronous reset mid-frame.
module tb_spi_reg_ctl;

  localparam int GAP = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       vld;
  logic [7:0] din;
  logic [7:0] miso;
  logic [6:0] reg_addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       fdone;

  int vecs = 0;
  int errs = 0;

  logic [7:0] mem [128];
  bit   [6:0] wa_q[$];
  bit   [7:0] wd_q[$];
  bit   [6:0] ra_q[$];
  int         fd_cnt = 0;
  int         ovl_cnt = 0;

  spi_reg_ctl #(.ADDR_WIDTH(7), .STATUS_BYTE(8'hA5)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .spi_cs_n_i     (cs_n),
    .spi_byte_vld_i (vld),
    .spi_byte_data_i(din),
    .spi_byte_data_o(miso),
    .reg_addr_o     (reg_addr),
    .reg_wr_en_o    (wr_en),
    .reg_wr_data_o  (wr_data),
    .reg_rd_en_o    (rd_en),
    .reg_rd_data_i  (rd_data),
    .frame_done_o   (fdone)
  );

  always #5 clk = ~clk;

  // Register-bank stub: read data valid one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[reg_addr];
  end

  // Strobe logger, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(reg_addr);
      wd_q.push_back(wr_data);
    end
    if (rd_en) ra_q.push_back(reg_addr);
    if (wr_en && rd_en) ovl_cnt++;
    if (fdone) fd_cnt++;
  end

  task automatic clear_logs();
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    fd_cnt = 0;
  endtask

  task automatic cs_low();
    @(posedge clk); #1 cs_n = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic cs_high();
    @(posedge clk); #1 cs_n = 1'b1;
    repeat (6) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] m);
    @(posedge clk); #1 vld = 1'b1; din = b;
    @(posedge clk); #1 vld = 1'b0;
    m = miso;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; vld = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #2;
    if (miso !== 8'h00) begin $display("FAIL reset_miso: got %h want 00", miso); errs++; end
    vecs++;
    if (reg_addr !== 7'h00) begin $display("FAIL reset_addr: got %h want 00", reg_addr); errs++; end
    vecs++;
    if ({wr_en, rd_en, fdone} !== 3'b000) begin
      $display("FAIL reset_strobes: got %b want 000", {wr_en, rd_en, fdone}); errs++;
    end
    vecs++;
    if (wr_data !== 8'h00) begin $display("FAIL reset_wdata: got %h want 00", wr_data); errs++; end
    vecs++;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_write_burst();
    logic [7:0] m [4];
    logic [6:0] ea [3];
    logic [7:0] ed [3];
    ea = '{7'h05, 7'h06, 7'h07};
    ed = '{8'h11, 8'h22, 8'h33};
    clear_logs();
    cs_low();
    send_byte(8'h05, m[0]);
    send_byte(8'h11, m[1]);
    send_byte(8'h22, m[2]);
    send_byte(8'h33, m[3]);
    if (m[0] !== 8'h00) begin $display("FAIL wr_miso0: got %h want 00", m[0]); errs++; end
    vecs++;
    if (m[1] !== 8'h11) begin $display("FAIL wr_miso1: got %h want 11", m[1]); errs++; end
    vecs++;
    if (m[2] !== 8'h22) begin $display("FAIL wr_miso2: got %h want 22", m[2]); errs++; end
    vecs++;
    cs_high();
    if (wa_q.size() !== 3) begin $display("FAIL wr_count: got %0d want 3", wa_q.size()); errs++; end
    vecs++;
    for (int i = 0; i < 3; i++) begin
      if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i]) begin
        $display("FAIL wr_strobe%0d: got %h/%h want %h/%h", i, wa_q[i], wd_q[i], ea[i], ed[i]);
        errs++;
      end
      vecs++;
    end
    if (ra_q.size() !== 0) begin $display("FAIL wr_no_rd: got %0d want 0", ra_q.size()); errs++; end
    vecs++;
    if (fd_cnt !== 1) begin $display("FAIL wr_fdone: got %0d want 1", fd_cnt); errs++; end
    vecs++;
    if (miso !== 8'h00) begin $display("FAIL wr_miso_idle: got %h want 00", miso); errs++; end
    vecs++;
  endtask

  task automatic test_read_burst();
    logic [7:0] m [5];
    logic [7:0] em [4];
    logic [6:0] ea [5];
    em = '{8'hA5, 8'hAA, 8'hBB, 8'hCC};
    ea = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h14};
    clear_logs();
    cs_low();
    send_byte(8'h90, m[0]);
    for (int i = 1; i < 5; i++) send_byte(8'hFF, m[i]);
    for (int i = 0; i < 4; i++) begin
      if (m[i] !== em[i]) begin
        $display("FAIL rd_miso%0d: got %h want %h", i + 1, m[i], em[i]); errs++;
      end
      vecs++;
    end
    cs_high();
    if (ra_q.size() !== 5) begin $display("FAIL rd_count: got %0d want 5", ra_q.size()); errs++; end
    vecs++;
    for (int i = 0; i < 5; i++) begin
      if (ra_q[i] !== ea[i]) begin
        $display("FAIL rd_addr%0d: got %h want %h", i, ra_q[i], ea[i]); errs++;
      end
      vecs++;
    end
    if (wa_q.size() !== 0) begin $display("FAIL rd_no_wr: got %0d want 0", wa_q.size()); errs++; end
    vecs++;
    if (fd_cnt !== 1) begin $display("FAIL rd_fdone: got %0d want 1", fd_cnt); errs++; end
    vecs++;
  endtask

  task automatic test_addr_wrap();
    logic [7:0] m;
    clear_logs();
    cs_low();
    send_byte(8'h7F, m);
    send_byte(8'h01, m);
    send_byte(8'h02, m);
    cs_high();
    if (wa_q.size() !== 2) begin $display("FAIL wrap_count: got %0d want 2", wa_q.size()); errs++; end
    vecs++;
    if (wa_q[0] !== 7'h7F || wd_q[0] !== 8'h01) begin
      $display("FAIL wrap_w0: got %h/%h want 7f/01", wa_q[0], wd_q[0]); errs++;
    end
    vecs++;
    if (wa_q[1] !== 7'h00 || wd_q[1] !== 8'h02) begin
      $display("FAIL wrap_w1: got %h/%h want 00/02", wa_q[1], wd_q[1]); errs++;
    end
    vecs++;
  endtask

  task automatic test_abort();
    logic [7:0] m;
    clear_logs();
    cs_low();
    @(posedge clk); #1 vld = 1'b1; din = 8'h85;
    @(posedge clk); #1 vld = 1'b0;
    if (rd_en !== 1'b1 || miso !== 8'hA5) begin
      $display("FAIL abort_req: got rd_en=%b miso=%h want 1/a5", rd_en, miso); errs++;
    end
    vecs++;
    @(posedge clk); #1 cs_n = 1'b1;
    @(posedge clk); #1;
    if (miso !== 8'h00) begin $display("FAIL abort_miso: got %h want 00", miso); errs++; end
    vecs++;
    repeat (40) @(posedge clk);
    if (ra_q.size() !== 1 || ra_q[0] !== 7'h05) begin
      $display("FAIL abort_rd: got n=%0d a=%h want 1/05", ra_q.size(), ra_q[0]); errs++;
    end
    vecs++;
    if (wa_q.size() !== 0) begin $display("FAIL abort_no_wr: got %0d want 0", wa_q.size()); errs++; end
    vecs++;
    if (fd_cnt !== 1) begin $display("FAIL abort_fdone: got %0d want 1", fd_cnt); errs++; end
    vecs++;
    clear_logs();
    cs_low();
    send_byte(8'h03, m);
    send_byte(8'h44, m);
    cs_high();
    if (wa_q.size() !== 1 || wa_q[0] !== 7'h03 || wd_q[0] !== 8'h44) begin
      $display("FAIL abort_next: got n=%0d %h/%h want 1 03/44", wa_q.size(), wa_q[0], wd_q[0]); errs++;
    end
    vecs++;
    if (ra_q.size() !== 0) begin $display("FAIL abort_next_rd: got %0d want 0", ra_q.size()); errs++; end
    vecs++;
  endtask

  task automatic test_vld_cs_coincide();
    logic [7:0] m;
    clear_logs();
    cs_low();
    send_byte(8'h20, m);
    send_byte(8'h55, m);
    @(posedge clk); #1 vld = 1'b1; din = 8'h66; cs_n = 1'b1;
    @(posedge clk); #1 vld = 1'b0;
    repeat (6) @(posedge clk);
    if (wa_q.size() !== 1) begin $display("FAIL coinc_count: got %0d want 1", wa_q.size()); errs++; end
    vecs++;
    if (wa_q[0] !== 7'h20 || wd_q[0] !== 8'h55) begin
      $display("FAIL coinc_w0: got %h/%h want 20/55", wa_q[0], wd_q[0]); errs++;
    end
    vecs++;
    if (fd_cnt !== 1) begin $display("FAIL coinc_fdone: got %0d want 1", fd_cnt); errs++; end
    vecs++;
    if (miso !== 8'h00) begin $display("FAIL coinc_miso: got %h want 00", miso); errs++; end
    vecs++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] m;
    clear_logs();
    cs_low();
    send_byte(8'h90, m);
    send_byte(8'hFF, m);
    if (m !== 8'hAA) begin $display("FAIL rst_pre_miso: got %h want aa", m); errs++; end
    vecs++;
    #3 rst_n = 1'b0;
    #1;
    if (miso !== 8'h00 || reg_addr !== 7'h00) begin
      $display("FAIL rst_async: got miso=%h addr=%h want 00/00", miso, reg_addr); errs++;
    end
    vecs++;
    if ({wr_en, rd_en, fdone} !== 3'b000) begin
      $display("FAIL rst_async_strobes: got %b want 000", {wr_en, rd_en, fdone}); errs++;
    end
    vecs++;
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    fd_cnt = 0;
    cs_low();
    cs_high();
    if (fd_cnt !== 0) begin $display("FAIL rst_empty_fdone: got %0d want 0", fd_cnt); errs++; end
    vecs++;
    clear_logs();
    cs_low();
    send_byte(8'h90, m);
    if (m !== 8'hA5) begin $display("FAIL rst_fresh_m0: got %h want a5", m); errs++; end
    vecs++;
    send_byte(8'hFF, m);
    if (m !== 8'hAA) begin $display("FAIL rst_fresh_m1: got %h want aa", m); errs++; end
    vecs++;
    send_byte(8'hFF, m);
    if (m !== 8'hBB) begin $display("FAIL rst_fresh_m2: got %h want bb", m); errs++; end
    vecs++;
    cs_high();
    if (fd_cnt !== 1) begin $display("FAIL rst_fresh_fdone: got %0d want 1", fd_cnt); errs++; end
    vecs++;
  endtask

  task automatic test_no_overlap();
    if (ovl_cnt !== 0) begin $display("FAIL overlap: got %0d want 0", ovl_cnt); errs++; end
    vecs++;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'(i ^ 8'h5A);
    mem[16] = 8'hAA;
    mem[17] = 8'hBB;
    mem[18] = 8'hCC;
    rd_data = '0;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_addr_wrap();
    test_abort();
    test_vld_cs_coincide();
    test_reset_mid();
    test_no_overlap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
